lspc_irq_ctrl: RTL and testbench

- Interrupt pending/acknowledge stage directly downstream of lspc_timer.
- Consumes the timer IRQ (lspc_timer D46A_OUT), the vblank trigger and the cold-boot reset event.
- Holds one pending flag per source, clears flags on 68k writes to REG_IRQACK, and drives the registered, priority-encoded, active-low nIPL[2:0] to the 68k.

---
 rtl/lspc_irq_pkg.sv | 32 +++
 rtl/lspc_irq_edge.sv | 27 ++
 rtl/lspc_irq_ctrl.sv | 106 ++++++++++
 tb/tb_lspc_irq_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lspc_irq_pkg.sv
// Shared definitions for the LSPC interrupt pending/acknowledge stage:
// the pending-flag bit positions, the active-low 68k level codes and the
// priority encoder that maps pending flags to a level.
package lspc_irq_pkg;

  // Position of each source inside the pending vector
  localparam int IRQ_BIT_RESET = 0;
  localparam int IRQ_BIT_TIMER = 1;
  localparam int IRQ_BIT_VBL   = 2;

  // Active-low nIPL codes; levels 4-7 are never driven
  localparam logic [2:0] IPL_NONE = 3'b111;
  localparam logic [2:0] IPL_L1   = 3'b110;
  localparam logic [2:0] IPL_L2   = 3'b101;
  localparam logic [2:0] IPL_L3   = 3'b100;

  typedef logic [2:0] irq_vec_t;

  // Highest pending source wins: reset (L3) over timer (L2) over vblank (L1)
  function automatic logic [2:0] irq_encode_ipl(input irq_vec_t pending);
    logic [2:0] ipl;
    ipl = IPL_NONE;
    if (pending[IRQ_BIT_RESET])
      ipl = IPL_L3;
    else if (pending[IRQ_BIT_TIMER])
      ipl = IPL_L2;
    else if (pending[IRQ_BIT_VBL])
      ipl = IPL_L1;
    return ipl;
  endfunction

endpackage

// File: rtl/lspc_irq_edge.sv
// Rising-edge detector for one interrupt source. The previous-value
// register has a configurable reset value so a source that is already
// high when reset is released does not produce a spurious edge. The gate
// input qualifies the set pulse without affecting edge tracking.
module lspc_irq_edge #(
  parameter bit PREV_RESET = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic gate,
  output logic rise
);

  logic prev;

  // Track the source level every cycle, regardless of the gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev <= PREV_RESET;
    else
      prev <= sig;
  end

  assign rise = sig & ~prev & gate;

endmodule

// File: rtl/lspc_irq_ctrl.sv
// LSPC interrupt controller: holds one pending flag per source (reset,
// timer, vblank), clears flags on REG_IRQACK writes and drives a
// registered, priority-encoded, active-low nIPL to the 68k.
// Optional build macro LSPC_IRQ_OVERRUN_CNT_EN adds a saturating counter
// of timer edges that arrive while the timer flag is still pending.
module lspc_irq_ctrl
  import lspc_irq_pkg::*;
#(
  parameter bit RESET_IRQ_AT_BOOT = 1'b1
`ifdef LSPC_IRQ_OVERRUN_CNT_EN
  ,
  parameter int OVR_WIDTH = 8
`endif
) (
  input  logic                 LSPC_6M,
  input  logic                 nRESET,
  input  logic                 TIMER_IRQ,
  input  logic                 VBL_TRIG,
  input  logic                 VBL_IRQ_EN,
  input  logic                 WR_IRQ_ACK,
  input  logic [2:0]           ACK_DATA,
  output logic [2:0]           nIPL,
  output irq_vec_t             IRQ_PENDING
`ifdef LSPC_IRQ_OVERRUN_CNT_EN
  ,
  output logic [OVR_WIDTH-1:0] TIMER_OVR_CNT
`endif
);

  localparam irq_vec_t PENDING_RESET = {2'b00, RESET_IRQ_AT_BOOT};

  logic     timer_set;
  logic     vbl_set;
  irq_vec_t ack_mask;
  irq_vec_t set_vec;
  irq_vec_t pending;
  irq_vec_t pending_next;
  logic [2:0] nipl_q;

  // Timer request is always armed; its PREV starts low
  lspc_irq_edge #(
    .PREV_RESET (1'b0)
  ) u_timer_edge (
    .clk   (LSPC_6M),
    .rst_n (nRESET),
    .sig   (TIMER_IRQ),
    .gate  (1'b1),
    .rise  (timer_set)
  );

  // Vblank PREV starts high so a vblank in progress at release is ignored
  lspc_irq_edge #(
    .PREV_RESET (1'b1)
  ) u_vbl_edge (
    .clk   (LSPC_6M),
    .rst_n (nRESET),
    .sig   (VBL_TRIG),
    .gate  (VBL_IRQ_EN),
    .rise  (vbl_set)
  );

  // Next pending state: a set beats a same-cycle ack so no event is lost
  always_comb begin
    ack_mask               = WR_IRQ_ACK ? ACK_DATA : '0;
    set_vec                = '0;
    set_vec[IRQ_BIT_TIMER] = timer_set;
    set_vec[IRQ_BIT_VBL]   = vbl_set;
    pending_next           = set_vec | (pending & ~ack_mask);
  end

  // Pending flags; the reset IRQ is only ever raised by reset itself
  always_ff @(posedge LSPC_6M or negedge nRESET) begin
    if (!nRESET)
      pending <= PENDING_RESET;
    else
      pending <= pending_next;
  end

  // nIPL follows the registered flags one cycle later
  always_ff @(posedge LSPC_6M or negedge nRESET) begin
    if (!nRESET)
      nipl_q <= IPL_NONE;
    else
      nipl_q <= irq_encode_ipl(pending);
  end

  assign IRQ_PENDING = pending;
  assign nIPL        = nipl_q;

`ifdef LSPC_IRQ_OVERRUN_CNT_EN
  logic [OVR_WIDTH-1:0] ovr_cnt;

  // Count absorbed timer edges; an ack of the timer flag restarts the count
  always_ff @(posedge LSPC_6M or negedge nRESET) begin
    if (!nRESET)
      ovr_cnt <= '0;
    else if (ack_mask[IRQ_BIT_TIMER])
      ovr_cnt <= '0;
    else if (timer_set && pending[IRQ_BIT_TIMER] && (ovr_cnt != '1))
      ovr_cnt <= ovr_cnt + 1'b1;
  end

  assign TIMER_OVR_CNT = ovr_cnt;
`endif

endmodule

// File: tb/tb_lspc_irq_ctrl.sv
// Testbench for lspc_irq_ctrl. Directed vectors are driven on the falling
// edge; each vector pushes its hand-computed expected outputs into a
// queue, and a monitor pops and compares them just after the rising edge.
// Build with LSPC_IRQ_OVERRUN_CNT_EN to also check TIMER_OVR_CNT.
module tb_lspc_irq_ctrl;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       timer_irq;
  logic       vbl_trig;
  logic       vbl_irq_en;
  logic       wr_irq_ack;
  logic [2:0] ack_data;
  logic [2:0] n_ipl;
  logic [2:0] irq_pending;
`ifdef LSPC_IRQ_OVERRUN_CNT_EN
  logic [7:0] timer_ovr_cnt;
`endif

  typedef struct {
    logic [2:0] pend;
    logic [2:0] nipl;
    logic [7:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  cur_exp;
  string cur_name;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  lspc_irq_ctrl dut (
    .LSPC_6M       (clk),
    .nRESET        (n_reset),
    .TIMER_IRQ     (timer_irq),
    .VBL_TRIG      (vbl_trig),
    .VBL_IRQ_EN    (vbl_irq_en),
    .WR_IRQ_ACK    (wr_irq_ack),
    .ACK_DATA      (ack_data),
    .nIPL          (n_ipl),
    .IRQ_PENDING   (irq_pending)
`ifdef LSPC_IRQ_OVERRUN_CNT_EN
    ,
    .TIMER_OVR_CNT (timer_ovr_cnt)
`endif
  );

  // Compare one observed value against its expectation
  task automatic checkOutput(input string nm, input string what,
                             input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %b expected %b", nm, what, got, want);
    end
  endtask

  // Drive one vector on the falling edge and queue its expected result
  task automatic applyStimulus(input logic rst_v, input logic t, input logic v,
                               input logic en, input logic wr,
                               input logic [2:0] ack,
                               input logic [2:0] exp_pend,
                               input logic [2:0] exp_nipl,
                               input logic [7:0] exp_cnt, input string nm);
    exp_t e;
    @(negedge clk);
    n_reset    = rst_v;
    timer_irq  = t;
    vbl_trig   = v;
    vbl_irq_en = en;
    wr_irq_ack = wr;
    ack_data   = ack;
    e.pend = exp_pend;
    e.nipl = exp_nipl;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one expectation per rising edge, sampled just after it
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur_exp  = exp_q.pop_front();
      cur_name = name_q.pop_front();
      checkOutput(cur_name, "IRQ_PENDING", {5'b0, irq_pending}, {5'b0, cur_exp.pend});
      checkOutput(cur_name, "nIPL", {5'b0, n_ipl}, {5'b0, cur_exp.nipl});
`ifdef LSPC_IRQ_OVERRUN_CNT_EN
      checkOutput(cur_name, "TIMER_OVR_CNT", timer_ovr_cnt, cur_exp.cnt);
`endif
    end
  end

  initial begin
    logic [7:0] ec;
    logic [2:0] rise_nipl;
    n_reset    = 1'b0;
    timer_irq  = 1'b0;
    vbl_trig   = 1'b0;
    vbl_irq_en = 1'b0;
    wr_irq_ack = 1'b0;
    ack_data   = 3'b000;

    // rst t v en wr ack    pend    nipl    cnt
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 3'b111, 8'd0, "reset_hold");
    applyStimulus(0, 0, 0, 0, 0, 3'b000, 3'b001, 3'b111, 8'd0, "reset_hold2");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b001, 3'b100, 8'd0, "boot_irq");
    applyStimulus(1, 0, 0, 0, 1, 3'b001, 3'b000, 3'b100, 8'd0, "ack_reset");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 8'd0, "ack_reset_ipl");

    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b010, 3'b111, 8'd0, "timer_pulse");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b010, 3'b101, 8'd0, "timer_ipl");
    applyStimulus(1, 0, 0, 0, 1, 3'b010, 3'b000, 3'b101, 8'd0, "timer_ack");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 8'd0, "timer_ack_ipl");

    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b010, 3'b111, 8'd0, "hold_first");
    for (int i = 0; i < 9; i++)
      applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b010, 3'b101, 8'd0, "hold_level");
    applyStimulus(1, 1, 0, 0, 1, 3'b010, 3'b000, 3'b101, 8'd0, "hold_ack");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 8'd0, "hold_done");

    applyStimulus(1, 1, 1, 1, 0, 3'b000, 3'b110, 3'b111, 8'd0, "both_set");
    applyStimulus(1, 0, 1, 1, 0, 3'b000, 3'b110, 3'b101, 8'd0, "both_prio");
    applyStimulus(1, 0, 1, 1, 1, 3'b010, 3'b100, 3'b101, 8'd0, "both_ack_t");
    applyStimulus(1, 0, 1, 1, 0, 3'b000, 3'b100, 3'b110, 8'd0, "vbl_only");
    applyStimulus(1, 0, 1, 1, 1, 3'b100, 3'b000, 3'b110, 8'd0, "vbl_ack");
    applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 3'b111, 8'd0, "vbl_ack_ipl");

    applyStimulus(1, 0, 1, 1, 0, 3'b000, 3'b100, 3'b111, 8'd0, "vbl_set");
    applyStimulus(1, 0, 1, 0, 0, 3'b000, 3'b100, 3'b110, 8'd0, "en_off_keep");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b100, 3'b110, 8'd0, "en_off_keep2");
    applyStimulus(1, 0, 0, 0, 1, 3'b100, 3'b000, 3'b110, 8'd0, "vbl_ack2");
    applyStimulus(1, 0, 1, 0, 0, 3'b000, 3'b000, 3'b111, 8'd0, "vbl_disabled");
    applyStimulus(1, 0, 1, 1, 0, 3'b000, 3'b000, 3'b111, 8'd0, "en_late");
    applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 3'b111, 8'd0, "vbl_low");

    applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b010, 3'b111, 8'd0, "timer_set2");
    applyStimulus(1, 0, 0, 0, 1, 3'b000, 3'b010, 3'b101, 8'd0, "ack_zero");
    applyStimulus(1, 0, 0, 0, 1, 3'b101, 3'b010, 3'b101, 8'd0, "ack_other");
    applyStimulus(1, 0, 0, 0, 0, 3'b010, 3'b010, 3'b101, 8'd0, "data_no_wr");
    applyStimulus(1, 1, 0, 0, 1, 3'b010, 3'b010, 3'b101, 8'd0, "set_beats_ack");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b010, 3'b101, 8'd0, "set_kept");

    applyStimulus(0, 0, 1, 1, 0, 3'b000, 3'b001, 3'b111, 8'd0, "mid_reset");
    applyStimulus(0, 0, 1, 1, 0, 3'b000, 3'b001, 3'b111, 8'd0, "mid_reset2");
    applyStimulus(1, 0, 1, 1, 0, 3'b000, 3'b001, 3'b100, 8'd0, "release_vbl_hi");
    applyStimulus(1, 0, 1, 1, 0, 3'b000, 3'b001, 3'b100, 8'd0, "no_spurious_vbl");
    applyStimulus(1, 0, 0, 0, 1, 3'b001, 3'b000, 3'b100, 8'd0, "ack_reset2");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 8'd0, "idle");

    for (int k = 0; k < 300; k++) begin
      ec        = (k > 255) ? 8'd255 : 8'(k);
      rise_nipl = (k == 0) ? 3'b111 : 3'b101;
      applyStimulus(1, 1, 0, 0, 0, 3'b000, 3'b010, rise_nipl, ec, "ovr_rise");
      applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b010, 3'b101, ec, "ovr_fall");
    end
    applyStimulus(1, 0, 0, 0, 1, 3'b010, 3'b000, 3'b101, 8'd0, "ovr_ack");
    applyStimulus(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 8'd0, "ovr_idle");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
